// File: rtl/ov7670_cfg_seq_if.sv
// Command bus between the OV7670 configuration sequencer and the SCCB master.
// The sequencer presents one register write at a time. A write is transferred
// on any rising edge where cmd_valid and cmd_ready are both high.
`timescale 1ns/1ps
interface ov7670_cfg_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;

    // Sequencer side: drives the write request and its payload.
    modport master (
        output cmd_valid,
        output cmd_reg,
        output cmd_data,
        input  cmd_ready
    );

    // SCCB master side: accepts writes.
    modport slave (
        input  cmd_valid,
        input  cmd_reg,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/ov7670_cfg_seq.sv
// OV7670 configuration sequencer.
// At start-up it walks an external registered table of {reg, value} words
// and forwards each entry to the SCCB master. Two table words are reserved:
// DELAY_TAG pauses for DELAY_CYCLES clocks, and END_TAG ends the table.
// Once initialisation is complete, it services exposure updates from the
// HDR controller. Each 16-bit exposure value is split into writes to the
// AECHH, AECH and COM1 registers.
`timescale 1ns/1ps
module ov7670_cfg_seq #(
    parameter int          ADDR_W       = 8,
    parameter int          DEPTH        = 76,
    parameter int          DELAY_CYCLES = 2_500_000,
    parameter logic [15:0] DELAY_TAG    = 16'hFFF0,
    parameter logic [15:0] END_TAG      = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [15:0]         rom_data,
    ov7670_cfg_seq_if.master    cmd,
    input  logic                exp_req,
    input  logic [15:0]         exp_value,
    output logic                init_done,
    output logic                busy,
    output logic                exp_done
);

    // The delay counter runs from DELAY_CYCLES-1 down to 0. It is sized to
    // hold that start value, with a minimum width of one bit.
    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // OV7670 exposure registers.
    localparam logic [7:0] REG_AECHH = 8'h07;
    localparam logic [7:0] REG_AECH  = 8'h10;
    localparam logic [7:0] REG_COM1  = 8'h04;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_SEND,
        ST_DELAY,
        ST_FINISH,
        ST_IDLE,
        ST_EXP0,
        ST_EXP1,
        ST_EXP2
    } state_t;

    state_t             state_reg;
    logic [ADDR_W-1:0]  rom_addr_reg;
    logic               cmd_valid_reg;
    logic [7:0]         cmd_addr_reg;
    logic [7:0]         cmd_data_reg;
    logic               init_done_reg;
    logic               busy_reg;
    logic               exp_done_reg;
    logic [CNT_W-1:0]   cnt_reg;

    // exp_snap_reg always holds the most recent request.
    // exp_work_reg is frozen for the duration of one three-write sequence,
    // so a newer request cannot tear a sequence that is already in flight.
    logic               exp_pend_reg;
    logic [15:0]        exp_snap_reg;
    logic [15:0]        exp_work_reg;

    // Payload and successor state for the exposure write currently in progress.
    logic [7:0]         exp_cmd_addr;
    logic [7:0]         exp_cmd_data;
    state_t             exp_state_next;

    // Select the exposure register, value slice and next state from the current EXP state.
    always_comb begin
        exp_cmd_addr   = REG_AECHH;
        exp_cmd_data   = {2'b00, exp_work_reg[15:10]};
        exp_state_next = ST_EXP1;
        case (state_reg)
            ST_EXP1: begin
                exp_cmd_addr   = REG_AECH;
                exp_cmd_data   = exp_work_reg[9:2];
                exp_state_next = ST_EXP2;
            end
            ST_EXP2: begin
                exp_cmd_addr   = REG_COM1;
                exp_cmd_data   = {6'b000000, exp_work_reg[1:0]};
                exp_state_next = ST_IDLE;
            end
            default: ;
        endcase
    end

    // Main sequencer FSM: table walk, delays, the idle/restart arbiter and exposure writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_FETCH;
            rom_addr_reg  <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_addr_reg  <= 8'h00;
            cmd_data_reg  <= 8'h00;
            init_done_reg <= 1'b0;
            busy_reg      <= 1'b0;
            exp_done_reg  <= 1'b0;
            cnt_reg       <= '0;
            exp_pend_reg  <= 1'b0;
            exp_snap_reg  <= 16'h0000;
            exp_work_reg  <= 16'h0000;
        end else begin
            exp_done_reg <= 1'b0;

            case (state_reg)
                ST_FETCH: begin
                    // rom_addr is already stable here; the ROM registers it on this edge.
                    busy_reg  <= 1'b1;
                    state_reg <= ST_WAIT;
                end

                ST_WAIT: begin
                    state_reg <= ST_DECODE;
                end

                ST_DECODE: begin
                    if (rom_data == END_TAG) begin
                        state_reg <= ST_FINISH;
                    end else if (rom_data == DELAY_TAG) begin
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= ST_DELAY;
                    end else begin
                        cmd_addr_reg  <= rom_data[15:8];
                        cmd_data_reg  <= rom_data[7:0];
                        cmd_valid_reg <= 1'b1;
                        state_reg     <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    // Hold the payload steady until the SCCB master accepts it.
                    if (cmd.cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        if (rom_addr_reg == LAST_ADDR) begin
                            state_reg <= ST_FINISH;
                        end else begin
                            rom_addr_reg <= rom_addr_reg + 1'b1;
                            state_reg    <= ST_FETCH;
                        end
                    end
                end

                ST_DELAY: begin
                    if (cnt_reg == '0) begin
                        if (rom_addr_reg == LAST_ADDR) begin
                            state_reg <= ST_FINISH;
                        end else begin
                            rom_addr_reg <= rom_addr_reg + 1'b1;
                            state_reg    <= ST_FETCH;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                ST_FINISH: begin
                    init_done_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end

                ST_IDLE: begin
                    if (restart) begin
                        init_done_reg <= 1'b0;
                        rom_addr_reg  <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_FETCH;
                    end else if (exp_pend_reg) begin
                        exp_pend_reg <= 1'b0;
                        exp_work_reg <= exp_snap_reg;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_EXP0;
                    end
                end

                ST_EXP0, ST_EXP1, ST_EXP2: begin
                    // First cycle in each EXP state presents the write; a
                    // later handshake retires it and moves to the next one.
                    if (!cmd_valid_reg) begin
                        cmd_addr_reg  <= exp_cmd_addr;
                        cmd_data_reg  <= exp_cmd_data;
                        cmd_valid_reg <= 1'b1;
                    end else if (cmd.cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        state_reg     <= exp_state_next;
                        if (state_reg == ST_EXP2) begin
                            exp_done_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase

            // A new request is accepted in every state. It is assigned last so
            // that a request on the EXP0-entry cycle keeps the flag set.
            if (exp_req) begin
                exp_pend_reg <= 1'b1;
                exp_snap_reg <= exp_value;
            end
        end
    end

    assign rom_addr      = rom_addr_reg;
    assign cmd.cmd_valid = cmd_valid_reg;
    assign cmd.cmd_reg   = cmd_addr_reg;
    assign cmd.cmd_data  = cmd_data_reg;
    assign init_done     = init_done_reg;
    assign busy          = busy_reg;
    assign exp_done      = exp_done_reg;

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Directed testbench for ov7670_cfg_seq.
// A registered table ROM and a 4-entry DUT (DELAY_CYCLES=10) cover:
// table writes, delay markers, handshake stalls, exposure sequences,
// asynchronous reset, the depth boundary, END_TAG at index 0, and restart.
`timescale 1ns/1ps
module tb_ov7670_cfg_seq;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int DLY    = 10;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              restart   = 1'b0;
    logic              exp_req   = 1'b0;
    logic [15:0]       exp_value = 16'h0000;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              init_done;
    logic              busy;
    logic              exp_done;

    logic [15:0]       rom_mem [0:(1<<ADDR_W)-1];

    int checks   = 0;
    int failures = 0;

    ov7670_cfg_seq_if bus();

    ov7670_cfg_seq #(
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .DELAY_CYCLES (DLY),
        .DELAY_TAG    (16'hFFF0),
        .END_TAG      (16'hFFFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cmd       (bus),
        .exp_req   (exp_req),
        .exp_value (exp_value),
        .init_done (init_done),
        .busy      (busy),
        .exp_done  (exp_done)
    );

    always #5 clk = ~clk;

    // Registered table ROM: data follows the address by one clock.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Transaction monitor. cyc counts rising edges, and hs_cyc / exp_done_cyc
    // record the edge number of the latest handshake / exp_done sample.
    int          cyc          = 0;
    int          hs_cyc       = 0;
    int          exp_done_cnt = 0;
    int          exp_done_cyc = 0;
    logic [15:0] txq [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
            txq.push_back({bus.cmd_reg, bus.cmd_data});
            hs_cyc <= cyc + 1;
            $display("txn t=%0t reg=0x%02h data=0x%02h", $time, bus.cmd_reg, bus.cmd_data);
        end
        if (exp_done) begin
            exp_done_cnt <= exp_done_cnt + 1;
            exp_done_cyc <= cyc + 1;
        end
    end

    int tx_base  = 0;
    int exp_base = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int ntx();
        return txq.size() - tx_base;
    endfunction

    function automatic logic [15:0] tx(input int i);
        if (tx_base + i < txq.size())
            return txq[tx_base + i];
        return 16'hxxxx;
    endfunction

    task automatic load_table(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < (1<<ADDR_W); i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
        rom_mem[3] = w3;
    endtask

    // Hold reset for two cycles; release is done separately by start_run.
    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_run();
        tx_base  = txq.size();
        exp_base = exp_done_cnt;
        rst_n    = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.cmd_valid !== 1'b1 && n < max);
        chk(tag, 32'(bus.cmd_valid), 32'd1);
    endtask

    task automatic wait_init(input string tag, input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (init_done !== 1'b1 && n < max);
        chk(tag, 32'(init_done), 32'd1);
    endtask

    task automatic wait_exp(input string tag, input int count, input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_done_cnt - exp_base) < count && n < max);
        chk(tag, 32'(exp_done_cnt - exp_base), 32'(count));
    endtask

    initial begin
        int n;
        int lat;
        bus.cmd_ready = 1'b1;

        // 1: two writes then END_TAG, with cmd_ready tied high.
        load_table(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
        hold_reset();
        chk("rst_rom_addr",  32'(rom_addr),      32'h0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'h0);
        chk("rst_cmd_reg",   32'(bus.cmd_reg),   32'h0);
        chk("rst_cmd_data",  32'(bus.cmd_data),  32'h0);
        chk("rst_init_done", 32'(init_done),     32'h0);
        chk("rst_busy",      32'(busy),          32'h0);
        chk("rst_exp_done",  32'(exp_done),      32'h0);
        start_run();
        wait_valid("t1_first_valid", 10, n);
        chk("t1_first_latency", 32'(n), 32'd3);
        chk("t1_first_reg",  32'(bus.cmd_reg),  32'h12);
        chk("t1_first_data", 32'(bus.cmd_data), 32'h80);
        wait_init("t1_init_done", 40);
        lat = cyc - hs_cyc;
        chk("t1_init_latency", 32'(lat >= 3 && lat <= 4), 32'd1);
        chk("t1_count", 32'(ntx()), 32'd2);
        chk("t1_w0", 32'(tx(0)), 32'h1280);
        chk("t1_w1", 32'(tx(1)), 32'h1204);
        chk("t1_busy_after", 32'(busy), 32'h0);

        // 2: delay marker at index 0, DELAY_CYCLES=10.
        load_table(16'hFFF0, 16'h1180, 16'hFFFF, 16'hFFFF);
        hold_reset();
        start_run();
        wait_valid("t2_valid", 60, n);
        chk("t2_valid_latency", 32'(n), 32'd16);
        chk("t2_reg",      32'(bus.cmd_reg),  32'h11);
        chk("t2_data",     32'(bus.cmd_data), 32'h80);
        chk("t2_rom_addr", 32'(rom_addr),     32'h1);
        wait_init("t2_init_done", 40);
        chk("t2_count", 32'(ntx()), 32'd1);

        // 3: cmd_ready held low for 7 cycles on the first write.
        load_table(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
        bus.cmd_ready = 1'b0;
        hold_reset();
        start_run();
        wait_valid("t3_valid", 10, n);
        for (int i = 0; i < 7; i++) begin
            chk("t3_hold_valid", 32'(bus.cmd_valid), 32'h1);
            chk("t3_hold_reg",   32'(bus.cmd_reg),   32'h12);
            chk("t3_hold_data",  32'(bus.cmd_data),  32'h80);
            @(negedge clk);
        end
        chk("t3_no_transfer_yet", 32'(ntx()), 32'd0);
        bus.cmd_ready = 1'b1;
        wait_init("t3_init_done", 40);
        chk("t3_count", 32'(ntx()), 32'd2);
        chk("t3_w0", 32'(tx(0)), 32'h1280);
        chk("t3_w1", 32'(tx(1)), 32'h1204);

        // 4: exposure 0xABCD after init, then 0x0001 requested mid-sequence.
        @(negedge clk);
        exp_value = 16'hABCD;
        exp_req   = 1'b1;
        @(negedge clk);
        exp_req   = 1'b0;
        exp_value = 16'h1234;
        n = 0;
        while (ntx() < 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_first_exp_write", 32'(ntx() >= 3), 32'd1);
        exp_value = 16'h0001;
        exp_req   = 1'b1;
        @(negedge clk);
        exp_req   = 1'b0;
        wait_exp("t4_exp_done_two", 2, 80);
        chk("t4_exp_done_timing", 32'(exp_done_cyc - hs_cyc), 32'd1);
        repeat (5) @(negedge clk);
        chk("t4_exp_done_pulses", 32'(exp_done_cnt - exp_base), 32'd2);
        chk("t4_count", 32'(ntx()), 32'd8);
        chk("t4_aechh", 32'(tx(2)), 32'h072A);
        chk("t4_aech",  32'(tx(3)), 32'h10F3);
        chk("t4_com1",  32'(tx(4)), 32'h0401);
        chk("t4_2_aechh", 32'(tx(5)), 32'h0700);
        chk("t4_2_aech",  32'(tx(6)), 32'h1000);
        chk("t4_2_com1",  32'(tx(7)), 32'h0401);
        chk("t4_busy_after", 32'(busy),      32'h0);
        chk("t4_init_kept",  32'(init_done), 32'h1);

        // 5: two requests during init collapse to a single sequence with the latest value.
        load_table(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
        hold_reset();
        start_run();
        @(negedge clk);
        exp_value = 16'h0004;
        exp_req   = 1'b1;
        @(negedge clk);
        exp_req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_value = 16'h0400;
        exp_req   = 1'b1;
        @(negedge clk);
        exp_req   = 1'b0;
        chk("t5_not_done_yet", 32'(init_done), 32'h0);
        wait_init("t5_init_done", 40);
        wait_exp("t5_exp_done", 1, 60);
        repeat (20) @(negedge clk);
        chk("t5_single_seq", 32'(exp_done_cnt - exp_base), 32'd1);
        chk("t5_count", 32'(ntx()), 32'd5);
        chk("t5_w0",    32'(tx(0)), 32'h1280);
        chk("t5_w1",    32'(tx(1)), 32'h1204);
        chk("t5_aechh", 32'(tx(2)), 32'h0701);
        chk("t5_aech",  32'(tx(3)), 32'h1000);
        chk("t5_com1",  32'(tx(4)), 32'h0400);

        // 6: asynchronous reset asserted while the second write is stalled in SEND.
        load_table(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
        hold_reset();
        start_run();
        wait_valid("t6_first_valid", 10, n);
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        wait_valid("t6_second_valid", 10, n);
        chk("t6_second_addr", 32'(rom_addr),     32'h1);
        chk("t6_second_data", 32'(bus.cmd_data), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.cmd_valid), 32'h0);
        chk("t6_async_addr",  32'(rom_addr),      32'h0);
        chk("t6_async_busy",  32'(busy),          32'h0);
        @(negedge clk);
        bus.cmd_ready = 1'b1;
        start_run();
        wait_valid("t6_restart_valid", 10, n);
        chk("t6_restart_latency", 32'(n),          32'd3);
        chk("t6_restart_addr",    32'(rom_addr),   32'h0);
        chk("t6_restart_data",    32'(bus.cmd_data), 32'h80);
        chk("t6_restart_init",    32'(init_done),  32'h0);
        wait_init("t6_init_done", 40);
        chk("t6_count", 32'(ntx()), 32'd2);

        // 7: table fills DEPTH with no END_TAG, so the sequencer stops after the last index.
        load_table(16'h1101, 16'h1102, 16'h1103, 16'h1104);
        hold_reset();
        start_run();
        wait_init("t7_init_done", 60);
        chk("t7_count",    32'(ntx()),    32'd4);
        chk("t7_last",     32'(tx(3)),    32'h1104);
        chk("t7_rom_addr", 32'(rom_addr), 32'h3);

        // 8: END_TAG at index 0 gives no writes.
        load_table(16'hFFFF, 16'h1101, 16'hFFFF, 16'hFFFF);
        hold_reset();
        start_run();
        wait_init("t8_init_done", 20);
        repeat (3) @(negedge clk);
        chk("t8_count", 32'(ntx()), 32'd0);

        // 9: restart from IDLE re-runs the table from index 0.
        load_table(16'h1155, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("t9_init_cleared", 32'(init_done), 32'h0);
        chk("t9_busy",         32'(busy),      32'h1);
        wait_valid("t9_valid", 10, n);
        chk("t9_reg",  32'(bus.cmd_reg),  32'h11);
        chk("t9_data", 32'(bus.cmd_data), 32'h55);
        wait_init("t9_init_done", 40);
        chk("t9_count", 32'(ntx()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
